// File: rtl/seg_pkg.sv
// seg_pkg: shared types, constants and the leading-zero helper for the digit-scan scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_pkg;

    localparam int         NUM_DIG   = 6;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Common-anode, active-low patterns for hex digits 0..F; bit 7 (dp) is off.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic [1:0] {LOAD, WAIT, DWELL} state_t;

    // One display image: six nibbles, per-digit points, blanking and enable.
    typedef struct packed {
        logic [4*NUM_DIG-1:0] data;
        logic [NUM_DIG-1:0]   point;
        logic                 blank_lz;
        logic                 en;
    } img_t;

    // Bit i set when digit i sits in the leading run of zero nibbles without a point.
    // The run is walked from the leftmost digit down; digit 0 is never part of it.
    function automatic logic [NUM_DIG-1:0] lz_blank_mask(
        input logic [4*NUM_DIG-1:0] data,
        input logic [NUM_DIG-1:0]   point
    );
        logic               run;
        logic [NUM_DIG-1:0] mask;
        run  = 1'b1;
        mask = '0;
        for (int i = NUM_DIG - 1; i >= 1; i--) begin
            run     = run && (data[4*i +: 4] == 4'h0) && !point[i];
            mask[i] = run;
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_scan_sched_if.sv
// seg_scan_sched_if: image-update and frame handshake bundle of the digit-scan scheduler.
// Latency: n/a (wires only).
// Backpressure: upd_valid/upd_ready for images, frame_valid/frame_ready for frames.
// Ports: upd_* carry a new image in; sel/seg/frame_valid carry a frame out; frame_ready back.
// master = the scheduler, slave = image source plus shift controller.
interface seg_scan_sched_if;
    logic        upd_valid;
    logic        upd_ready;
    logic [23:0] upd_data;
    logic [5:0]  upd_point;
    logic        upd_blank_lz;
    logic        upd_en;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic        frame_valid;
    logic        frame_ready;

    modport master (
        input  upd_valid, upd_data, upd_point, upd_blank_lz, upd_en, frame_ready,
        output upd_ready, sel, seg, frame_valid
    );

    modport slave (
        output upd_valid, upd_data, upd_point, upd_blank_lz, upd_en, frame_ready,
        input  upd_ready, sel, seg, frame_valid
    );
endinterface

// File: rtl/seg_hex_enc.sv
// seg_hex_enc: one hex nibble plus dp/blank flags to an active-low 8-segment pattern.
// Latency: combinational.
// Backpressure: none.
// Ports: nib (digit value), dp (light the point), blank (all segments off) -> seg.
module seg_hex_enc
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = HEX_SEG[nib];
        if (dp) begin
            seg[7] = 1'b0;
        end
        if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg_scan_sched.sv
// seg_scan_sched: walks six digits of a double-buffered image, one sel/seg frame per digit.
// Latency: frame registered one cycle after LOAD; digit period DWELL_CYC+2 with frame_ready high.
// Backpressure: frame_ready low stretches WAIT indefinitely; upd_ready low while a new image is pending.
// Ports: sys_clk, sys_rst (sync, active-high); bus = master side of seg_scan_sched_if.
module seg_scan_sched
    import seg_pkg::*;
#(
    parameter int DWELL_CYC = 50000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    seg_scan_sched_if.master  bus
);

    localparam int            CW       = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYC - 1);
    localparam logic [2:0]    IDX_LAST = 3'(NUM_DIG - 1);

    state_t               state;
    state_t               state_nxt;
    logic [2:0]           idx;
    logic [CW-1:0]        cnt;

    img_t                 act_img;
    img_t                 shd_img;
    logic                 shd_full;

    logic                 upd_fire;
    logic                 load_frame;
    logic                 frame_fire;
    logic                 dwell_done;
    logic                 wrap;

    logic [NUM_DIG-1:0]   lz_mask;
    logic [3:0]           dig_nib;
    logic                 dig_dp;
    logic                 dig_blank;
    logic [7:0]           dig_seg;

    logic [5:0]           sel_q;
    logic [7:0]           seg_q;
    logic                 fv_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    state_nxt = WAIT;
            WAIT:    if (bus.frame_ready) state_nxt = DWELL;
            DWELL:   if (cnt == CNT_LAST) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // ---------------- FSM: per-state strobes ----------------
    always_comb begin
        load_frame = (state == LOAD);
        frame_fire = (state == WAIT) && bus.frame_ready;
        dwell_done = (state == DWELL) && (cnt == CNT_LAST);
        wrap       = dwell_done && (idx == IDX_LAST);
    end

    // ---------------- Dwell counter and digit index ----------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            if (frame_fire) begin
                cnt <= '0;
            end else if (state == DWELL && !dwell_done) begin
                cnt <= cnt + CW'(1);
            end
            if (dwell_done) begin
                idx <= wrap ? 3'd0 : idx + 3'd1;
            end
        end
    end

    // ---------------- Shadow / active image ----------------
    // upd_ready is !shd_full, so an accept and a commit can never hit the same edge;
    // an image accepted on the wrap edge lands in the just-emptied... no: it lands in
    // an already-empty shadow and waits for the following wrap.
    assign upd_fire      = bus.upd_valid && !shd_full;
    assign bus.upd_ready = !shd_full;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            act_img  <= '0;
            shd_img  <= '0;
            shd_full <= 1'b0;
        end else begin
            if (upd_fire) begin
                shd_img  <= '{data:     bus.upd_data,
                              point:    bus.upd_point,
                              blank_lz: bus.upd_blank_lz,
                              en:       bus.upd_en};
                shd_full <= 1'b1;
            end else if (wrap && shd_full) begin
                act_img  <= shd_img;
                shd_full <= 1'b0;
            end
        end
    end

    // ---------------- Digit mux and encode ----------------
    assign lz_mask   = lz_blank_mask(act_img.data, act_img.point);
    assign dig_nib   = act_img.data[{idx, 2'b00} +: 4];
    assign dig_dp    = act_img.point[idx];
    assign dig_blank = act_img.blank_lz && lz_mask[idx];

    seg_hex_enc u_enc (
        .nib   (dig_nib),
        .dp    (dig_dp),
        .blank (dig_blank),
        .seg   (dig_seg)
    );

    // ---------------- Registered frame ----------------
    // A disabled image still produces frames on schedule, just with nothing selected.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sel_q <= '0;
            seg_q <= SEG_BLANK;
            fv_q  <= 1'b0;
        end else if (load_frame) begin
            sel_q <= act_img.en ? (6'b000001 << idx) : 6'b000000;
            seg_q <= act_img.en ? dig_seg : SEG_BLANK;
            fv_q  <= 1'b1;
        end else if (frame_fire) begin
            fv_q  <= 1'b0;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.seg         = seg_q;
    assign bus.frame_valid = fv_q;

endmodule

// File: tb/tb_seg_scan_sched.sv
// tb_seg_scan_sched: table vectors, directed corner sequences and random traffic for seg_scan_sched.
// Latency: n/a (testbench).
// Backpressure: frame_ready driven by the bench (tied, stalled or random).
module tb_seg_scan_sched;

    localparam int DW = 4;
    localparam int NV = 18;

    localparam logic [7:0] REF_HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef struct packed {
        logic [23:0] data;
        logic [5:0]  pt;
        logic        blz;
        logic        en;
    } timg_t;

    typedef struct {
        timg_t im;
        int    n;
    } pend_t;

    typedef struct {
        bit         load;
        timg_t      im;
        int         dig;
        logic [5:0] sel;
        logic [7:0] seg;
    } vec_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    seg_scan_sched_if bus();

    seg_scan_sched #(.DWELL_CYC(DW)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected frame from the image rules: everything above the most significant
    // "meaningful" digit (non-zero nibble or lit point) is blank when blanking is on.
    function automatic logic [13:0] ref_frame(input timg_t im, input int d);
        int         msd;
        logic [3:0] nib;
        logic [7:0] s;
        if (!im.en) return {6'b000000, 8'hFF};
        msd = 0;
        for (int k = 0; k < 6; k++)
            if (((im.data >> (4 * k)) & 24'hF) != 24'h0 || im.pt[k]) msd = k;
        nib = 4'((im.data >> (4 * d)) & 24'hF);
        if (im.blz && d > msd) s = 8'hFF;
        else begin
            s = REF_HEX[nib];
            if (im.pt[d]) s = s & 8'h7F;
        end
        return {6'(1 << d), s};
    endfunction

    // ---------------- Monitor / reference model ----------------
    int          samp = 0;
    logic        rst_prev = 1'b0;
    logic        fv_prev = 1'b0;
    bit          mdl_ok = 1'b0;
    timg_t       m_act;
    pend_t       pq[$];
    int          frame_no = 0;
    int          last_acc = -1;
    int          wrap_samp = -1;
    int          rst_samp = 0;
    logic [5:0]  cur_sel;
    logic [7:0]  cur_seg;
    int          acc_cnt = 0;
    int          last_acc_dig = 0;
    logic [5:0]  last_acc_sel;
    logic [7:0]  last_acc_seg;
    logic [13:0] m_exp;
    bit          m_rise;
    pend_t       m_p;

    always @(negedge sys_clk) begin
        samp = samp + 1;
        if (rst_prev) begin
            m_act     = '0;
            pq.delete();
            frame_no  = 0;
            last_acc  = -1;
            wrap_samp = -1;
            rst_samp  = samp;
            fv_prev   = 1'b0;
            mdl_ok    = 1'b1;
            chk("rst_sel", 32'(bus.sel), 32'h0);
            chk("rst_seg", 32'(bus.seg), 32'hFF);
            chk("rst_fv", 32'(bus.frame_valid), 32'h0);
        end
        rst_prev = sys_rst;
        if (!sys_rst && mdl_ok) begin
            if (samp == wrap_samp && pq.size() > 0 && pq[0].n <= samp - 2) begin
                m_act = pq[0].im;
                void'(pq.pop_front());
            end
            chk("upd_ready", 32'(bus.upd_ready), 32'(pq.size() == 0));
            m_rise = bus.frame_valid && !fv_prev;
            if (m_rise) begin
                m_exp = ref_frame(m_act, frame_no % 6);
                chk($sformatf("frame%0d_sel", frame_no), 32'(bus.sel), 32'(m_exp[13:8]));
                chk($sformatf("frame%0d_seg", frame_no), 32'(bus.seg), 32'(m_exp[7:0]));
                if (last_acc >= 0) chk("frame_gap", 32'(samp - last_acc), 32'(DW + 2));
                else               chk("first_frame_gap", 32'(samp - rst_samp), 32'd1);
                cur_sel = bus.sel;
                cur_seg = bus.seg;
            end else if (bus.frame_valid) begin
                chk("hold_sel", 32'(bus.sel), 32'(cur_sel));
                chk("hold_seg", 32'(bus.seg), 32'(cur_seg));
            end
            if (bus.frame_valid && bus.frame_ready) begin
                last_acc_dig = frame_no % 6;
                last_acc_sel = bus.sel;
                last_acc_seg = bus.seg;
                acc_cnt++;
                frame_no++;
                last_acc  = samp;
                wrap_samp = (last_acc_dig == 5) ? samp + DW + 1 : -1;
            end
            if (bus.upd_valid && bus.upd_ready) begin
                m_p.im = '{bus.upd_data, bus.upd_point, bus.upd_blank_lz, bus.upd_en};
                m_p.n  = samp;
                pq.push_back(m_p);
            end
            fv_prev = bus.frame_valid;
        end
    end

    // ---------------- Driver tasks ----------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic offer(input timg_t im);
        bit done = 1'b0;
        bus.upd_data     = im.data;
        bus.upd_point    = im.pt;
        bus.upd_blank_lz = im.blz;
        bus.upd_en       = im.en;
        bus.upd_valid    = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            done = bus.upd_ready;
            tick();
        end
        bus.upd_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL offer: upd_ready stayed %0b", bus.upd_ready);
        end
    endtask

    task automatic wait_digit(input int d, output logic [5:0] s, output logic [7:0] g);
        int seen = acc_cnt;
        bit got  = 1'b0;
        s = '0;
        g = '0;
        for (int i = 0; i < 400 && !got; i++) begin
            tick();
            if (acc_cnt != seen) begin
                seen = acc_cnt;
                if (last_acc_dig == d) begin
                    got = 1'b1;
                    s   = last_acc_sel;
                    g   = last_acc_seg;
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wait_digit%0d: no accepted frame, got 0 expected 1", d);
        end
    endtask

    task automatic load_image(input timg_t im);
        logic [5:0] s;
        logic [7:0] g;
        do_reset();
        offer(im);
        wait_digit(5, s, g);
    endtask

    // ---------------- Stimulus ----------------
    vec_t       vt [NV];
    logic [5:0] gs;
    logic [7:0] gg;
    logic [5:0] s0;
    logic [7:0] g0;
    int         n;
    bit         fire_now;
    timg_t      ia, ib, ir;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.upd_valid    = 1'b0;
        bus.upd_data     = '0;
        bus.upd_point    = '0;
        bus.upd_blank_lz = 1'b0;
        bus.upd_en       = 1'b0;
        bus.frame_ready  = 1'b1;

        ia = '{24'h012345, 6'h00, 1'b0, 1'b1};
        ib = '{24'h6789AB, 6'h00, 1'b0, 1'b1};

        vt[0]  = '{1'b1, ia, 0, 6'b000001, 8'h92};
        vt[1]  = '{1'b0, ia, 1, 6'b000010, 8'h99};
        vt[2]  = '{1'b0, ia, 5, 6'b100000, 8'hC0};
        vt[3]  = '{1'b1, '{24'h012345, 6'h00, 1'b1, 1'b1}, 5, 6'b100000, 8'hFF};
        vt[4]  = '{1'b0, '{24'h012345, 6'h00, 1'b1, 1'b1}, 4, 6'b010000, 8'hF9};
        vt[5]  = '{1'b0, '{24'h012345, 6'h00, 1'b1, 1'b1}, 0, 6'b000001, 8'h92};
        vt[6]  = '{1'b1, '{24'h000000, 6'h00, 1'b1, 1'b1}, 5, 6'b100000, 8'hFF};
        vt[7]  = '{1'b0, '{24'h000000, 6'h00, 1'b1, 1'b1}, 1, 6'b000010, 8'hFF};
        vt[8]  = '{1'b0, '{24'h000000, 6'h00, 1'b1, 1'b1}, 0, 6'b000001, 8'hC0};
        vt[9]  = '{1'b1, '{24'h000000, 6'b001000, 1'b1, 1'b1}, 5, 6'b100000, 8'hFF};
        vt[10] = '{1'b0, '{24'h000000, 6'b001000, 1'b1, 1'b1}, 4, 6'b010000, 8'hFF};
        vt[11] = '{1'b0, '{24'h000000, 6'b001000, 1'b1, 1'b1}, 3, 6'b001000, 8'h40};
        vt[12] = '{1'b0, '{24'h000000, 6'b001000, 1'b1, 1'b1}, 2, 6'b000100, 8'hC0};
        vt[13] = '{1'b1, '{24'hFFFFFF, 6'h00, 1'b0, 1'b0}, 0, 6'b000000, 8'hFF};
        vt[14] = '{1'b0, '{24'hFFFFFF, 6'h00, 1'b0, 1'b0}, 3, 6'b000000, 8'hFF};
        vt[15] = '{1'b1, '{24'h012345, 6'b000100, 1'b0, 1'b1}, 2, 6'b000100, 8'h30};
        vt[16] = '{1'b1, '{24'hABCDEF, 6'h00, 1'b0, 1'b1}, 0, 6'b000001, 8'h8E};
        vt[17] = '{1'b0, '{24'hABCDEF, 6'h00, 1'b0, 1'b1}, 5, 6'b100000, 8'h88};

        // Reset release: LOAD for one cycle, then the first frame appears.
        tick();
        do_reset();
        chk("post_rst_fv", 32'(bus.frame_valid), 32'h0);
        chk("post_rst_ready", 32'(bus.upd_ready), 32'h1);
        tick();
        chk("first_fv", 32'(bus.frame_valid), 32'h1);
        chk("first_sel_blank", 32'(bus.sel), 32'h0);

        // Table vectors.
        for (int i = 0; i < NV; i++) begin
            if (vt[i].load) load_image(vt[i].im);
            wait_digit(vt[i].dig, gs, gg);
            chk($sformatf("vec%0d_sel", i), 32'(gs), 32'(vt[i].sel));
            chk($sformatf("vec%0d_seg", i), 32'(gg), 32'(vt[i].seg));
        end

        // Image B offered during the digit-2 dwell commits only at the wrap.
        load_image(ia);
        wait_digit(2, gs, gg);
        offer(ib);
        chk("upd_b_ready_low", 32'(bus.upd_ready), 32'h0);
        wait_digit(3, gs, gg);
        chk("upd_d3_seg", 32'(gg), 32'hA4);
        wait_digit(5, gs, gg);
        chk("upd_d5_seg", 32'(gg), 32'hC0);
        chk("upd_d5_ready", 32'(bus.upd_ready), 32'h0);
        wait_digit(0, gs, gg);
        chk("upd_b_d0_seg", 32'(gg), 32'h83);
        chk("upd_b_ready_back", 32'(bus.upd_ready), 32'h1);
        wait_digit(5, gs, gg);
        chk("upd_b_d5_seg", 32'(gg), 32'h82);

        // frame_ready stall: frame held, dwell starts only after the accept.
        bus.frame_ready = 1'b0;
        for (int i = 0; i < 50 && !bus.frame_valid; i++) tick();
        s0 = bus.sel;
        g0 = bus.seg;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stall_fv", 32'(bus.frame_valid), 32'h1);
            chk("stall_sel", 32'(bus.sel), 32'(s0));
            chk("stall_seg", 32'(bus.seg), 32'(g0));
        end
        bus.frame_ready = 1'b1;
        tick();
        chk("stall_accept_fv", 32'(bus.frame_valid), 32'h0);
        n = 0;
        for (int i = 0; i < 50 && !bus.frame_valid; i++) begin
            tick();
            n++;
        end
        chk("stall_next_gap", 32'(n), 32'(DW + 1));

        // Reset mid-dwell with an image pending.
        load_image(ia);
        wait_digit(1, gs, gg);
        offer(ib);
        chk("rst_mid_in_dwell", 32'(bus.frame_valid), 32'h0);
        chk("rst_mid_pending", 32'(bus.upd_ready), 32'h0);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("rst_mid_sel", 32'(bus.sel), 32'h0);
        chk("rst_mid_seg", 32'(bus.seg), 32'hFF);
        chk("rst_mid_fv", 32'(bus.frame_valid), 32'h0);
        chk("rst_mid_ready", 32'(bus.upd_ready), 32'h1);
        wait_digit(0, gs, gg);
        chk("rst_mid_d0_sel", 32'(gs), 32'h0);
        wait_digit(5, gs, gg);
        wait_digit(0, gs, gg);
        chk("rst_mid_scan2_sel", 32'(gs), 32'h0);
        chk("rst_mid_scan2_seg", 32'(gg), 32'hFF);

        // Random traffic against the monitor's model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.frame_ready = ($urandom_range(0, 3) != 0);
            sys_rst = ($urandom_range(0, 599) == 0);
            fire_now = bus.upd_valid && bus.upd_ready;
            tick();
            if (fire_now) bus.upd_valid = 1'b0;
            if (!bus.upd_valid && $urandom_range(0, 15) == 0) begin
                ir.data = 24'($urandom) >> (4 * $urandom_range(0, 6));
                ir.pt   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
                ir.blz  = 1'($urandom);
                ir.en   = ($urandom_range(0, 5) != 0);
                bus.upd_data     = ir.data;
                bus.upd_point    = ir.pt;
                bus.upd_blank_lz = ir.blz;
                bus.upd_en       = ir.en;
                bus.upd_valid    = 1'b1;
            end
        end
        sys_rst = 1'b0;
        bus.upd_valid = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
